// File: rtl/clock_pkg.sv
// Shared encodings and period helper for the clock timebase.
package clock_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_NORM = 3'd0;
  localparam mode_t MODE_X100 = 3'd1;
  localparam mode_t MODE_X500 = 3'd2;
  localparam mode_t MODE_X50K = 3'd3;
  localparam mode_t MODE_BYP  = 3'd4;

  localparam int unsigned DIV_NORM = 1;
  localparam int unsigned DIV_X100 = 100;
  localparam int unsigned DIV_X500 = 500;
  localparam int unsigned DIV_X50K = 50000;

  // Second period in clock cycles. Bypass uses a period of one so the counter
  // wraps on every running cycle; unused codes fall back to normal speed.
  function automatic int unsigned sec_period(input mode_t mode, input int unsigned clk_hz);
    case (mode)
      MODE_X100: sec_period = clk_hz / DIV_X100;
      MODE_X500: sec_period = clk_hz / DIV_X500;
      MODE_X50K: sec_period = clk_hz / DIV_X50K;
      MODE_BYP:  sec_period = 1;
      default:   sec_period = clk_hz / DIV_NORM;
    endcase
  endfunction

endpackage

// File: rtl/clock_tick_gen_if.sv
// Control inputs and tick outputs of the clock timebase.
interface clock_tick_gen_if;
  import clock_pkg::*;

  mode_t mode;
  logic  run;
  logic  clr;
  logic  tick_sec;
  logic  tick_half;
  logic  blink;
  logic  tick_scan;

  modport master (
    output mode, run, clr,
    input  tick_sec, tick_half, blink, tick_scan
  );

  modport slave (
    input  mode, run, clr,
    output tick_sec, tick_half, blink, tick_scan
  );

endinterface

// File: rtl/tick_counter.sv
// Modulo-N counter with enable, synchronous clear and a registered wrap pulse.
module tick_counter #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] n_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             wrap_d, wrap_q;
  logic             last;

  assign last = (cnt_q == n_i - CNT_W'(1));

  // Next count: clear wins, otherwise advance and wrap at N-1.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (last) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/clock_tick_gen.sv
// Timebase: second, half-second and blink outputs in scaled time, plus a
// free-running display-scan tick. All outputs are single-cycle enables.
module clock_tick_gen
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned SCAN_HZ = 1000,
  parameter int unsigned CNT_W   = 26
) (
  input logic             clk_in_50M,
  input logic             rst_n,
  clock_tick_gen_if.slave bus
);

  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;

  mode_t            mode_q;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] half_last;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] unused_scan_cnt;
  logic             mode_chg, byp, sec_clr, sec_en;
  logic             wrap_hit, half_hit;
  logic             tick_half_d, tick_half_q;
  logic             blink_d, blink_q;
  logic             tick_sec, tick_scan;

  assign period    = CNT_W'(sec_period(mode_q, CLK_HZ));
  assign half_last = (period >> 1) - CNT_W'(1);

  // A mode change restarts the second timebase and swallows that cycle's tick.
  assign mode_chg = (bus.mode != mode_q);
  assign byp      = (mode_q == MODE_BYP);
  assign sec_clr  = bus.clr | mode_chg;
  assign sec_en   = bus.run & ~sec_clr;

  // Bypass wraps every cycle but must not produce half ticks or move blink.
  assign wrap_hit = sec_en & ~byp & (sec_cnt == period - CNT_W'(1));
  assign half_hit = sec_en & ~byp & (sec_cnt == half_last);

  // Next mid-period pulse and blink level.
  always_comb begin
    tick_half_d = half_hit;
    blink_d     = blink_q;
    if (bus.clr) begin
      blink_d = 1'b0;
    end else if (wrap_hit || half_hit) begin
      blink_d = ~blink_q;
    end
  end

  // Mode, half-tick and blink registers.
  always_ff @(posedge clk_in_50M or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_NORM;
      tick_half_q <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      mode_q      <= bus.mode;
      tick_half_q <= tick_half_d;
      blink_q     <= blink_d;
    end
  end

  tick_counter #(
    .CNT_W(CNT_W)
  ) u_sec (
    .clk_i (clk_in_50M),
    .rst_ni(rst_n),
    .en_i  (sec_en),
    .clr_i (sec_clr),
    .n_i   (period),
    .cnt_o (sec_cnt),
    .wrap_o(tick_sec)
  );

  tick_counter #(
    .CNT_W(CNT_W)
  ) u_scan (
    .clk_i (clk_in_50M),
    .rst_ni(rst_n),
    .en_i  (1'b1),
    .clr_i (1'b0),
    .n_i   (CNT_W'(SCAN_DIV)),
    .cnt_o (unused_scan_cnt),
    .wrap_o(tick_scan)
  );

  assign bus.tick_sec  = tick_sec;
  assign bus.tick_half = tick_half_q;
  assign bus.blink     = blink_q;
  assign bus.tick_scan = tick_scan;

endmodule

// File: tb/tb_clock_tick_gen.sv
// Scoreboard bench for clock_tick_gen: the driver predicts tick events from a
// running-cycle model and queues them; a monitor checks whatever the DUT emits.
module tb_clock_tick_gen;

  localparam int unsigned CLK_HZ   = 5_000_000;
  localparam int unsigned SCAN_HZ  = 1000;
  localparam int unsigned CNT_W    = 26;
  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;

  typedef struct {
    int unsigned cyc;
    logic        sec;
    logic        half;
    logic        scan;
    logic        blink;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clock_tick_gen_if bus ();

  clock_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_in_50M(clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;

  // Reference model state: edges since reset, running edges since last restart.
  int unsigned m_g;
  int unsigned m_n;
  logic [2:0]  m_mq;
  logic        m_blink;

  int unsigned edge_cnt;

  function automatic int unsigned period_of(input logic [2:0] m);
    case (m)
      3'd1:    return CLK_HZ / 100;
      3'd2:    return CLK_HZ / 500;
      3'd3:    return CLK_HZ / 50000;
      3'd4:    return 1;
      default: return CLK_HZ;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_g     = 0;
    m_n     = 0;
    m_mq    = 3'd0;
    m_blink = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the outcome of the coming edge, wait it.
  task automatic step(input logic [2:0] m, input logic r, input logic c);
    ev_t         e;
    int unsigned p;
    bus.mode = m;
    bus.run  = r;
    bus.clr  = c;
    m_g++;
    e.cyc  = m_g;
    e.sec  = 1'b0;
    e.half = 1'b0;
    e.scan = ((m_g % SCAN_DIV) == 0);
    if (c) begin
      m_n     = 0;
      m_blink = 1'b0;
    end else if (m != m_mq) begin
      m_n = 0;
    end else if (m_mq == 3'd4) begin
      e.sec = r;
    end else if (r) begin
      p = period_of(m_mq);
      m_n++;
      e.sec  = ((m_n % p) == 0);
      e.half = ((m_n % p) == p / 2);
      if (e.sec || e.half) m_blink = ~m_blink;
    end
    m_mq    = m;
    e.blink = m_blink;
    if (e.sec || e.half || e.scan) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Run in mode 3 until the running phase reaches ph (bounded).
  task automatic run_to_phase(input int unsigned ph, input string name);
    int unsigned k;
    k = 0;
    while (!(m_mq == 3'd3 && (m_n % period_of(3'd3)) == ph) && k < 1000) begin
      step(3'd3, 1'b1, 1'b0);
      k++;
    end
    n_checks++;
    if (k >= 1000) begin
      n_fail++;
      $display("FAIL %s: phase %0d not reached within %0d cycles", name, ph, k);
    end
  endtask

  // Testbench edge counter since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Monitor: flag overdue expectations, then match any emitted tick.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_tick: edge %0d got no tick, required sec=%0b half=%0b scan=%0b",
                 exp_q[0].cyc, exp_q[0].sec, exp_q[0].half, exp_q[0].scan);
        exp_q.delete(0);
      end
      if (bus.tick_sec || bus.tick_half || bus.tick_scan) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tick: edge %0d got sec=%0b half=%0b scan=%0b, required none",
                   edge_cnt, bus.tick_sec, bus.tick_half, bus.tick_scan);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != edge_cnt || mon_e.sec !== bus.tick_sec ||
              mon_e.half !== bus.tick_half || mon_e.scan !== bus.tick_scan ||
              mon_e.blink !== bus.blink) begin
            n_fail++;
            $display({"FAIL tick_event: got edge %0d sec=%0b half=%0b scan=%0b blink=%0b, ",
                      "required edge %0d sec=%0b half=%0b scan=%0b blink=%0b"},
                     edge_cnt, bus.tick_sec, bus.tick_half, bus.tick_scan, bus.blink,
                     mon_e.cyc, mon_e.sec, mon_e.half, mon_e.scan, mon_e.blink);
          end
        end
      end
    end
  end

  initial begin
    int unsigned total;
    int unsigned pick;
    int unsigned len;
    int unsigned k;
    logic [2:0]  m;

    bus.mode = 3'd3;
    bus.run  = 1'b0;
    bus.clr  = 1'b0;
    model_reset();

    #12;
    check("reset_outputs", 32'({bus.tick_sec, bus.tick_half, bus.blink, bus.tick_scan}), 32'd0);
    check("reset_mode_q", 32'(dut.mode_q), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Free run in mode 3.
    repeat (250) step(3'd3, 1'b1, 1'b0);

    // Pause for 30 cycles at phase 40; phase must be preserved.
    run_to_phase(40, "pause_phase");
    repeat (30) step(3'd3, 1'b0, 1'b0);
    check("pause_no_tick", 32'({bus.tick_sec, bus.tick_half}), 32'd0);
    repeat (150) step(3'd3, 1'b1, 1'b0);

    // Clear at phase 70.
    run_to_phase(70, "clear_phase");
    step(3'd3, 1'b1, 1'b1);
    check("clr_blink", 32'(bus.blink), 32'd0);
    check("clr_ticks", 32'({bus.tick_sec, bus.tick_half}), 32'd0);
    repeat (120) step(3'd3, 1'b1, 1'b0);

    // Mode switch 3 -> 2 mid-count.
    run_to_phase(30, "switch_phase");
    step(3'd2, 1'b1, 1'b0);
    check("switch_no_tick", 32'({bus.tick_sec, bus.tick_half}), 32'd0);
    repeat (10050) step(3'd2, 1'b1, 1'b0);

    // Clear together with a mode change.
    step(3'd3, 1'b1, 1'b1);
    check("clr_switch_blink", 32'(bus.blink), 32'd0);
    repeat (150) step(3'd3, 1'b1, 1'b0);

    // Bypass with run toggling and a clear.
    repeat (20) step(3'd4, 1'b1, 1'b0);
    check("bypass_sec", 32'(bus.tick_sec), 32'd1);
    repeat (3) step(3'd4, 1'b0, 1'b0);
    check("bypass_paused", 32'(bus.tick_sec), 32'd0);
    repeat (5) step(3'd4, 1'b1, 1'b0);
    step(3'd4, 1'b1, 1'b1);
    repeat (3) step(3'd4, 1'b1, 1'b0);

    // Randomized segments of mode, run and clr.
    total = 0;
    while (total < 20000) begin
      pick = $urandom_range(0, 99);
      len  = $urandom_range(40, 500);
      if (pick < 60)      m = 3'd3;
      else if (pick < 75) m = 3'd4;
      else if (pick < 85) m = 3'd2;
      else if (pick < 92) m = 3'd6;
      else                m = 3'd1;
      for (int i = 0; i < int'(len); i++) begin
        step(m, ($urandom_range(0, 9) != 0), ($urandom_range(0, 399) == 0));
      end
      total += len;
    end

    // Async reset one cycle before a second tick, with blink high.
    k = 0;
    while (!(m_mq == 3'd3 && (m_n % 100) == 99 && m_blink) && k < 1000) begin
      step(3'd3, 1'b1, 1'b0);
      k++;
    end
    check("reset_setup_bound", 32'(k < 1000), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", 32'({bus.tick_sec, bus.tick_half, bus.blink, bus.tick_scan}),
          32'd0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    check("async_reset_held", 32'({bus.tick_sec, bus.tick_half, bus.blink, bus.tick_scan}),
          32'd0);
    rst_n = 1'b1;
    repeat (250) step(3'd3, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_tick_gen.md
# clock_tick_gen

Parametrised timebase for the clock design. It derives a 1 Hz second tick, a half-second tick with a blink level, and a display-scan tick from the 50 MHz board clock. All outputs are single-cycle enables, not divided clocks. A runtime `mode` selects normal speed, ×100, ×500 or ×50000 acceleration, or a simulation bypass, replacing hand-edited divider chains. It sits at the top of the design and feeds the seconds counter and the display mux.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency in Hz. Must be divisible by 100000.
- `SCAN_HZ`, 1000: display-scan tick rate in Hz. `CLK_HZ/SCAN_HZ` must be ≥ 2.
- `CNT_W`, 26: counter width. Must hold `CLK_HZ-1`.
- `clk_in_50M` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `mode` in 3: speed select. 0 = normal (P = `CLK_HZ`), 1 = ×100 (P = `CLK_HZ`/100), 2 = ×500 (P = `CLK_HZ`/500), 3 = ×50000 (P = `CLK_HZ`/50000), 4 = bypass. Codes 5–7 behave as 0.
- `run` in 1: count enable (pause when low).
- `clr` in 1: synchronous clear of the second timebase.
- `tick_sec` out 1: one-cycle pulse per second period.
- `tick_half` out 1: one-cycle pulse at mid-period.
- `blink` out 1: level, toggles on every `tick_sec` and `tick_half` event.
- `tick_scan` out 1: one-cycle pulse every `CLK_HZ/SCAN_HZ` cycles.

## Operation
- **Reset values:** all outputs 0, both counters 0, registered mode `mode_q` = 0.
- **Second counter `cnt` (0..P-1):** on each edge with `run`=1, `cnt` increments. At `cnt`==P-1 it wraps to 0 and `tick_sec` is registered high for the next cycle. At `cnt`==P/2-1 (P is even for all modes) `tick_half` is registered high.
- **Pause:** `run`=0 holds `cnt` and suppresses `tick_sec` and `tick_half`. `blink` holds.
- **Clear:** `clr`=1 forces `cnt`←0 and `blink`←0, and suppresses ticks. `clr` has priority over `run`.
- **Mode change:** `mode` is registered into `mode_q` every cycle. When `mode` ≠ `mode_q`, `cnt`←0 and no tick fires that cycle. The new period applies from the next cycle.
- **Bypass (mode_q = 4):** `tick_sec` ← `run` registered, so it is high every cycle while running. `tick_half` stays 0. `blink` holds. `cnt` stays at 0.
- **Scan counter:** free-running modulo `CLK_HZ/SCAN_HZ`. Cleared only by `rst_n`. Independent of `mode`, `run` and `clr`.
- **Blink:** toggles in the same cycle `tick_sec` or `tick_half` is asserted. The result is a 1 Hz square wave in scaled time.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- **First tick after reset:** with `run`=1 continuously from the first edge after reset release, `tick_sec` is first high after exactly P edges. It then repeats every P cycles. `tick_half` is first high after P/2 edges.
- **Pause and resume:** the phase of `cnt` is preserved. Total running cycles between `tick_sec` pulses is always P.
- **Clear:** `clr` asserted on edge k gives `cnt`=0 after edge k. The next `tick_sec` follows P running edges after `clr` deasserts.
- **Async reset mid-count:** outputs drop to 0 immediately. Counting restarts from 0 after release.
- **Simultaneous `clr` and mode change:** same result as `clr`.

## Structure
- Package `clock_pkg` holds:
  - mode encodings (`MODE_NORM`, `MODE_X100`, `MODE_X500`, `MODE_X50K`, `MODE_BYP`);
  - divide factors 1/100/500/50000;
  - function `sec_period(mode, CLK_HZ)` returning P.
- Sub-module `tick_counter` is a modulo-N counter with enable, synchronous clear, runtime N input and a registered wrap pulse. It is instantiated for the second timebase (N = P) and the scan timebase (N = `CLK_HZ/SCAN_HZ`, enable tied high).

## Test plan
- **Mode 3 timing:** `CLK_HZ`=50_000_000, `mode`=3, `run`=1 → `tick_sec` first high after edge 1000 and again after edge 2000; `tick_half` after edges 500 and 1500; `blink` 0→1→0→1.
- **Pause:** mode 3, `run` low for 300 cycles starting at `cnt`=400 → `tick_sec` at running-cycle 1000, i.e. wall-clock edge 1300.
- **Clear:** `clr` pulse at `cnt`=700 → no tick at edge 1000; next `tick_sec` 1000 edges after the clear; `blink`=0 after the clear.
- **Mode switch:** mode 3→2 mid-count → no tick on the switch cycle; next `tick_sec` after 100000 edges.
- **Bypass and scan:** mode 4, `run`=1 → `tick_sec` high every cycle from the second edge; `tick_scan` pulses every 50000 cycles regardless of `mode`/`run`/`clr`.
- **Async reset:** `rst_n` low at `cnt`=999 → no tick emitted; all outputs 0 immediately.
